// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, constants, FSM states and the unpacked-operand
// type used by the sequential subtractor.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W:0]   sig;
        logic             zero;
    } operand_t;

    // A zero exponent flushes the operand (zero or denormal) to a zero significand.
    function automatic operand_t unpack_op(input logic [31:0] value, input logic flip);
        operand_t op;
        op.sign     = value[31] ^ flip;
        op.exponent = value[30:23];
        op.zero     = (value[30:23] == '0);
        op.sig      = op.zero ? '0 : {1'b1, value[MAN_W-1:0]};
        return op;
    endfunction

endpackage

// File: rtl/fp32_rne_round.sv
// Combinational round-to-nearest-even and FP32 packing with overflow to
// signed infinity. Significand layout: [26] hidden bit, [25:3] mantissa, G, R, S.
module fp32_rne_round
    import fp32_pkg::*;
(
    input  logic        sign,
    input  logic [9:0]  exponent,
    input  logic [26:0] significand,
    output logic [31:0] packed_val
);

    logic        inc;
    logic [24:0] rounded;
    logic [9:0]  exp_adj;

    always_comb begin
        inc     = significand[2] & (significand[1] | significand[0] | significand[3]);
        rounded = {1'b0, significand[26:3]} + {24'b0, inc};
        exp_adj = exponent + {9'b0, rounded[24]};
        // A rounding carry leaves 1.000..., so the mantissa field is all zeros.
        if (exp_adj >= 10'd255)
            packed_val = POS_INF | {sign, 31'b0};
        else if (rounded[24])
            packed_val = {sign, exp_adj[EXP_W-1:0], rounded[MAN_W:1]};
        else
            packed_val = {sign, exp_adj[EXP_W-1:0], rounded[MAN_W-1:0]};
    end

endmodule

// File: rtl/fp32_sub_seq.sv
// Iterative FP32 subtractor (result = a - b), RNE rounding, denormals flushed.
// Define FP32_SUB_SPECIALS_EN to decode exponent 255 as Inf/NaN.
module fp32_sub_seq
    import fp32_pkg::*;
#(
    parameter int NORM_MAX = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] result,
    output logic        busy
);

    localparam int CNT_W = $clog2(NORM_MAX + 1);

    state_t            state, state_nxt;
    logic [31:0]       a_reg, b_reg;
    operand_t          x_op, y_op, ua, ub;
    logic              swap;
    logic [7:0]        diff;
    logic [49:0]       wide;
    logic [26:0]       y_shift, y_al;
    logic [27:0]       sum, sum_nxt;
    logic              mag_zero;
    logic [9:0]        exp_w;
    logic              sign_w, flush, special;
    logic [CNT_W-1:0]  norm_cnt;
    logic [31:0]       spec_res, spec_val, rounded;
    logic              is_special;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_comb begin
        ua       = unpack_op(a_reg, 1'b0);
        ub       = unpack_op(b_reg, 1'b1);
        swap     = {ub.exponent, ub.sig} > {ua.exponent, ua.sig};
        diff     = x_op.exponent - y_op.exponent;
        wide     = {y_op.sig, 26'b0} >> diff;
        y_shift  = (diff > 8'd26) ? {26'b0, |y_op.sig} : {wide[49:24], |wide[23:0]};
        sum_nxt  = (x_op.sign == y_op.sign) ? {1'b0, x_op.sig, 3'b000} + {1'b0, y_al}
                                            : {1'b0, x_op.sig, 3'b000} - {1'b0, y_al};
        mag_zero = (sum_nxt == '0) || (x_op.zero && y_op.zero);
    end

`ifdef FP32_SUB_SPECIALS_EN
    logic a_inf, b_inf, a_nan, b_nan;
    always_comb begin
        a_inf      = (&a_reg[30:23]) && (a_reg[22:0] == '0);
        b_inf      = (&b_reg[30:23]) && (b_reg[22:0] == '0);
        a_nan      = (&a_reg[30:23]) && (a_reg[22:0] != '0);
        b_nan      = (&b_reg[30:23]) && (b_reg[22:0] != '0);
        is_special = (&a_reg[30:23]) || (&b_reg[30:23]);
        if (a_nan || b_nan || (a_inf && b_inf && (a_reg[31] == b_reg[31])))
            spec_val = QNAN;
        else if (a_inf)
            spec_val = a_reg;
        else
            spec_val = {~b_reg[31], POS_INF[30:0]};
    end
`else
    assign is_special = 1'b0;
    assign spec_val   = '0;
`endif

    fp32_rne_round u_round (
        .sign        (sign_w),
        .exponent    (exp_w),
        .significand (sum[26:0]),
        .packed_val  (rounded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NORM exits once the sum has no carry and a set hidden bit, on flush, or on watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = is_special ? S_ROUND : S_ALIGN;
            S_ALIGN:  state_nxt = S_ADD;
            S_ADD:    state_nxt = S_NORM;
            S_NORM:   if (flush || norm_cnt == CNT_W'(NORM_MAX) || (!sum[27] && sum[26]))
                          state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            x_op     <= '0;
            y_op     <= '0;
            y_al     <= '0;
            sum      <= '0;
            exp_w    <= '0;
            sign_w   <= 1'b0;
            flush    <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
            norm_cnt <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                S_UNPACK: begin
                    x_op     <= swap ? ub : ua;
                    y_op     <= swap ? ua : ub;
                    special  <= is_special;
                    spec_res <= spec_val;
                    flush    <= 1'b0;
                    norm_cnt <= '0;
                end
                S_ALIGN: y_al <= y_shift;
                S_ADD: begin
                    sum    <= sum_nxt;
                    exp_w  <= {2'b00, x_op.exponent};
                    sign_w <= mag_zero ? 1'b0 : x_op.sign;
                    flush  <= mag_zero;
                end
                S_NORM: begin
                    if (!flush && norm_cnt != CNT_W'(NORM_MAX)) begin
                        if (sum[27]) begin
                            sum      <= {1'b0, sum[27:2], sum[1] | sum[0]};
                            exp_w    <= exp_w + 10'd1;
                            norm_cnt <= norm_cnt + CNT_W'(1);
                        end else if (!sum[26]) begin
                            sum      <= {sum[26:0], 1'b0};
                            exp_w    <= exp_w - 10'd1;
                            flush    <= (exp_w == 10'd1);
                            norm_cnt <= norm_cnt + CNT_W'(1);
                        end
                    end
                end
                S_ROUND: begin
                    done <= 1'b1;
                    if (special)
                        result <= spec_res;
                    else if (flush)
                        result <= {sign_w, 31'b0};
                    else
                        result <= rounded;
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    norm_watchdog_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == S_NORM && norm_cnt == CNT_W'(NORM_MAX)));
`endif

endmodule
